// File: rtl/demux_frame_sequencer_pkg.sv
// demux_frame_sequencer_pkg: shared sizing constants and state encoding for the demux sequencer
package demux_frame_sequencer_pkg;
  localparam int NUM_CH = 14;
  localparam int DATA_W = 8;
  localparam int SEL_W = 4;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/demux_frame_sequencer_next_chan_finder.sv
// next_chan_finder: lowest enabled channel above cur, or from index 0 when from_start is set
module next_chan_finder
  import demux_frame_sequencer_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  input  logic              from_start,
  output logic [SEL_W-1:0]  nxt,
  output logic              found
);
  always_comb begin
    nxt = '0;
    found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (mask[i] && (from_start || SEL_W'(i) > cur)) begin
        nxt = SEL_W'(i);
        found = 1'b1;
      end
  end
endmodule

// File: rtl/demux_frame_sequencer.sv
// demux_frame_sequencer: walks the demux select through a frame's enabled channels, one strobe per sample
module demux_frame_sequencer
  import demux_frame_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [NUM_CH-1:0] chan_en,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] data_out,
  output logic [NUM_CH-1:0] load_stb,
  output logic              frame_done,
  output logic              busy,
  output logic              err
);
  state_t state, state_n;
  logic [NUM_CH-1:0] mask, mask_n, stb_n;
  logic [SEL_W-1:0] sel_n, f_idx;
  logic [DATA_W-1:0] data_n;
  logic f_found, done_n, err_n;
  // one finder serves both the first-channel search (live chan_en) and advancing (latched mask)
  next_chan_finder u_find (
    .mask(state == IDLE ? chan_en : mask),
    .cur(sel),
    .from_start(state == IDLE),
    .nxt(f_idx),
    .found(f_found)
  );
  assign busy = state == RUN;
  assign in_ready = busy & ~abort;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      mask <= '0;
      sel <= '0;
      data_out <= '0;
      load_stb <= '0;
      frame_done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      mask <= mask_n;
      sel <= sel_n;
      data_out <= data_n;
      load_stb <= stb_n;
      frame_done <= done_n;
      err <= err_n;
    end
  always_comb begin
    state_n = state;
    mask_n = mask;
    sel_n = sel;
    data_n = data_out;
    stb_n = '0;
    done_n = 1'b0;
    err_n = 1'b0;
    if (state == IDLE) begin
      err_n = start && ~|chan_en;
      if (start && |chan_en) begin
        state_n = RUN;
        mask_n = chan_en;
        sel_n = f_idx;
      end
    end else if (abort) begin
      state_n = IDLE;
      sel_n = '0;
    end else if (in_valid) begin
      data_n = in_data;
      stb_n = NUM_CH'(1) << sel;
      sel_n = f_found ? f_idx : '0;
      done_n = ~f_found;
      state_n = f_found ? RUN : IDLE;
    end
  end
endmodule

// File: tb/tb_demux_frame_sequencer.sv
// tb_demux_frame_sequencer: scoreboard bench; expected strobes queued at handshake, popped when load_stb fires
module tb_demux_frame_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, in_valid = 1'b0;
  logic [13:0] chan_en = '0;
  logic [7:0] in_data = '0;
  logic in_ready, frame_done, busy, err;
  logic [3:0] sel;
  logic [7:0] data_out;
  logic [13:0] load_stb;
  typedef struct {logic [13:0] stb; logic [7:0] d; logic done;} exp_t;
  exp_t sb[$];
  int n_pass = 0, n_tot = 0;
  logic m_run = 1'b0;
  logic [13:0] m_mask = '0;
  int m_sel = 0;
  demux_frame_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .chan_en(chan_en),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
    .data_out(data_out), .load_stb(load_stb), .frame_done(frame_done),
    .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  function automatic int next_ch(input logic [13:0] m, input int from);
    for (int i = from; i < 14; i++) if (m[i]) return i;
    return -1;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (load_stb != 0) begin
        if (sb.size() == 0) chk("stb_unexpected", {18'd0, load_stb}, 0);
        else begin
          e = sb.pop_front();
          chk("load_stb", {18'd0, load_stb}, {18'd0, e.stb});
          chk("data_out", {24'd0, data_out}, {24'd0, e.d});
          chk("frame_done", {31'd0, frame_done}, {31'd0, e.done});
        end
      end else if (frame_done) chk("done_without_stb", 1, 0);
    end
  end
  task automatic do_start(input logic [13:0] m, input logic a);
    chk("busy_pre_start", {31'd0, busy}, 0);
    start = 1'b1;
    chan_en = m;
    abort = a;
    m_run = m != 0;
    m_mask = m;
    m_sel = next_ch(m, 0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chan_en = ~m;
    chk("err_after_start", {31'd0, err}, {31'd0, m == 0});
  endtask
  task automatic step(input logic v, input logic [7:0] d, input logic a);
    int nx;
    in_valid = v;
    in_data = d;
    abort = a;
    #1;
    chk("busy", {31'd0, busy}, {31'd0, m_run});
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_run && !a});
    if (m_run) chk("sel", {28'd0, sel}, m_sel);
    if (m_run && a) begin
      m_run = 1'b0;
      m_sel = 0;
    end else if (m_run && v) begin
      nx = next_ch(m_mask, m_sel + 1);
      sb.push_back('{stb: 14'(1) << m_sel, d: d, done: nx < 0});
      m_run = nx >= 0;
      m_sel = nx < 0 ? 0 : nx;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    abort = 1'b0;
  endtask
  initial begin
    @(negedge clk);
    chk("rst_sel", {28'd0, sel}, 0);
    chk("rst_outs", {data_out, load_stb, frame_done, busy, err, in_ready}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(14'h3FFF, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b1, 8'(i), 1'b0);
    do_start(14'h2024, 1'b0);
    step(1'b1, 8'hA1, 1'b0);
    step(1'b1, 8'hB2, 1'b0);
    step(1'b1, 8'hC3, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    do_start(14'h0005, 1'b0);
    step(1'b1, 8'h11, 1'b0);
    step(1'b0, 8'h22, 1'b0);
    step(1'b0, 8'h33, 1'b0);
    step(1'b1, 8'h44, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    do_start(14'h0000, 1'b0);
    chk("err_idle_busy", {31'd0, busy}, 0);
    chk("err_idle_ready", {31'd0, in_ready}, 0);
    step(1'b0, 8'h00, 1'b0);
    chk("err_one_cycle", {31'd0, err}, 0);
    step(1'b0, 8'h00, 1'b1);
    do_start(14'h00FF, 1'b1);
    step(1'b1, 8'h50, 1'b0);
    step(1'b1, 8'h51, 1'b0);
    step(1'b1, 8'h52, 1'b0);
    step(1'b1, 8'h53, 1'b1);
    chk("abort_sel", {28'd0, sel}, 0);
    step(1'b1, 8'h54, 1'b0);
    do_start(14'h0003, 1'b0);
    step(1'b1, 8'h60, 1'b0);
    step(1'b1, 8'h61, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    do_start(14'h00FF, 1'b0);
    step(1'b1, 8'h70, 1'b0);
    step(1'b1, 8'h71, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sel", {28'd0, sel}, 0);
    chk("midrst_outs", {data_out, load_stb, frame_done, busy, err, in_ready}, 0);
    m_run = 1'b0;
    m_sel = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(14'h0001, 1'b0);
    step(1'b1, 8'h99, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
